// File: rtl/plru_way_selector_pkg.sv
// Shared constants and types for the 8-way tree pseudo-LRU tracker.
// The way multiplexors use the same WAYS/WAY_BITS values.
package plru_way_selector_pkg;

    localparam int WAYS      = 8;
    localparam int WAY_BITS  = 3;
    localparam int TREE_BITS = 7;

    // Node 0 is the root, nodes 1..2 form level 1, nodes 3..6 are the leaves
    localparam logic [2:0] ROOT_NODE = 3'd0;
    localparam logic [2:0] L1_BASE   = 3'd1;
    localparam logic [2:0] LEAF_BASE = 3'd3;

    typedef logic [TREE_BITS-1:0] tree_t;
    typedef logic [WAY_BITS-1:0]  way_t;

endpackage

// File: rtl/plru_way_selector_if.sv
// Lookup request / replacement response bundle between the tag array and the PLRU tracker.
interface plru_way_selector_if
    import plru_way_selector_pkg::*;
#(
    parameter int INDEX_BITS = 4
);

    logic                  req_valid;
    logic [INDEX_BITS-1:0] req_index;
    logic [WAYS-1:0]       req_hit_vec;
    logic                  rsp_valid;
    way_t                  rsp_way;
    logic                  rsp_hit;
    logic                  rsp_err;

    modport master (
        output req_valid, req_index, req_hit_vec,
        input  rsp_valid, rsp_way, rsp_hit, rsp_err
    );

    modport slave (
        input  req_valid, req_index, req_hit_vec,
        output rsp_valid, rsp_way, rsp_hit, rsp_err
    );

endinterface

// File: rtl/plru_way_selector_hit_encoder.sv
// Combinational hit-vector encoder: lowest-index way wins, flags any and multi-hot hits.
module hit_encoder
    import plru_way_selector_pkg::*;
(
    input  logic [WAYS-1:0] hit_vec,
    output way_t            way,
    output logic            any,
    output logic            multi
);

    always_comb begin
        way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                way = WAY_BITS'(i);
            end
        end
        any   = |hit_vec;
        // Clearing the lowest set bit leaves something only if two or more were set
        multi = |(hit_vec & (hit_vec - WAYS'(1)));
    end

endmodule

// File: rtl/plru_way_selector.sv
// Per-set tree pseudo-LRU tracker: encodes hits, picks victims on misses,
// and touches the addressed set's tree, with a one-cycle registered response.
module plru_way_selector
    import plru_way_selector_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    plru_way_selector_if.slave bus
);

    tree_t trees [SETS];

    tree_t cur_tree;
    tree_t next_tree;
    way_t  enc_way;
    way_t  victim;
    way_t  sel_way;
    logic  enc_any;
    logic  enc_multi;
    logic  walk_root;
    logic  walk_mid;
    logic  [2:0] mid_node;
    logic  [2:0] leaf_node;
    logic  [INDEX_BITS-1:0] index;

    logic  rsp_valid_q;
    way_t  rsp_way_q;
    logic  rsp_hit_q;
    logic  rsp_err_q;

    hit_encoder u_hit_encoder (
        .hit_vec (bus.req_hit_vec),
        .way     (enc_way),
        .any     (enc_any),
        .multi   (enc_multi)
    );

    // Victim walk follows the node bits down; touch points every node on the path away from the chosen way
    always_comb begin
        index     = bus.req_index;
        cur_tree  = trees[index];
        walk_root = cur_tree[ROOT_NODE];
        mid_node  = L1_BASE + {2'b00, walk_root};
        walk_mid  = cur_tree[mid_node];
        leaf_node = LEAF_BASE + {1'b0, walk_root, walk_mid};
        victim    = {walk_root, walk_mid, cur_tree[leaf_node]};
        sel_way   = enc_any ? enc_way : victim;

        next_tree = cur_tree;
        next_tree[ROOT_NODE]                          = ~sel_way[2];
        next_tree[L1_BASE + {2'b00, sel_way[2]}]      = ~sel_way[1];
        next_tree[LEAF_BASE + {1'b0, sel_way[2:1]}]   = ~sel_way[0];
    end

    // A multi-hot lookup is reported but never allowed to disturb the replacement state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                trees[s] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= bus.req_valid;
            if (bus.req_valid) begin
                rsp_way_q <= sel_way;
                rsp_hit_q <= enc_any;
                rsp_err_q <= enc_multi;
                if (!enc_multi) begin
                    trees[index] <= next_tree;
                end
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_way   = rsp_way_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/plru_way_selector.md
# plru_way_selector

Per-set tree pseudo-LRU replacement tracker for the 8-way L2 model; it produces the 3-bit way select that drives the way multiplexors. On every tag lookup it takes the set index and per-way hit vector. For a hit, it encodes the hit way. For a miss, it picks the victim way. In both cases it updates that set's replacement state. The response is registered with one cycle of latency.

## Interface
- `SETS`, default 16: number of cache sets; must be a power of two, at least 2.
- `INDEX_BITS`, default 4: equals log2(SETS).
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid`, input, 1: lookup request present this cycle.
- `req_index`, input, INDEX_BITS: set index of the request.
- `req_hit_vec`, input, 8: per-way tag-match bits; bit i means way i hit.
- `rsp_valid`, output, 1: response valid, exactly one cycle after an accepted request.
- `rsp_way`, output, 3: selected way, either the hit way or the victim way.
- `rsp_hit`, output, 1: 1 means hit, 0 means miss/victim.
- `rsp_err`, output, 1: more than one bit of `req_hit_vec` was set.

## Operation
- State is one 7-bit tree per set, `SETS` x 7 flops. Node 0 is the root; node n has children 2n+1 and 2n+2. Leaf nodes 3..6 cover way pairs {0,1}, {2,3}, {4,5}, {6,7}.
- Node bit meaning: 0 means the victim lies in the lower-numbered half; 1 means the upper half.
- Victim walk: start at node 0, take the lower or upper child per the bit, for three levels. This yields way 0..7.
- Touch of way w: along w's path, set each node to point away from w. Root is 1 if w<4, else 0; the level-1 and leaf nodes follow the same rule.
- Request with exactly one hit bit set: `rsp_way` is the encoded index, `rsp_hit`=1. The set's tree is touched with that way.
- Request with an all-zero hit vector: `rsp_way` is the victim from the current tree, `rsp_hit`=0. The tree is touched with the victim, since the fill is assumed.
- Request with a multi-hot hit vector: `rsp_err`=1, `rsp_hit`=1, `rsp_way` is the lowest set bit. The tree is not updated.
- Only the addressed set changes; all other sets hold their value.
- No request: trees hold; `rsp_valid`=0. `rsp_way`, `rsp_hit` and `rsp_err` hold their last values.

## Timing
- Reset: all tree bits 0, `rsp_valid`=0, `rsp_way`=0, `rsp_hit`=0, `rsp_err`=0. A fresh set therefore victimises way 0 first.
- Latency: request at edge k produces the response registered at edge k+1. The tree is updated at the same edge k+1.
- Throughput: one request per cycle with no stall and no backpressure.
- Back-to-back requests to the same set: the second request must see the tree as updated by the first. The tree is read combinationally from the flops, so no bypass is needed.
- Reset while `req_valid`=1: the request is dropped, and `rsp_valid`=0 on the following cycle.
- A request arriving in the cycle after reset deassertion is processed normally.

## Structure
- Shared package/include holds `WAYS`=8, `WAY_BITS`=3, `TREE_BITS`=7, plus the node-index helper constants. The same values are used by the way multiplexors.
- Sub-module `hit_encoder` is combinational: 8-bit one-hot in, 3-bit way, `any` and `multi` out. It uses lowest-index priority.
- Victim walk and touch logic live in the top-level module. The tree array sits in the top level as a register file indexed by `req_index`.

## Test plan
- Reset, then 9 consecutive misses to set 0 -> `rsp_way` sequence 0,4,2,6,1,5,3,7,0 with `rsp_hit`=0.
- After reset, hit vector 8'h01 on set 3, then a miss on set 3 -> responses (way 0, hit) then (way 4, miss). A following miss on set 5 -> way 0, showing set independence.
- Hit vector 8'h80 on set 1, followed the next cycle by a miss on set 1 -> way 7 then way 0. This checks back-to-back update visibility.
- Hit vector 8'h24 on set 2 -> `rsp_err`=1, `rsp_way`=2. A following miss on set 2 -> way 0, confirming the tree is unchanged.
- Issue 3 misses to set 6, then assert `rst_n`=0 for one cycle with `req_valid`=1 -> `rsp_valid`=0 in the next cycle. The next miss to set 6 -> way 0.
- Idle cycles with `req_valid`=0 between requests -> `rsp_valid` drops and no tree changes. The sequence then resumes exactly where it left off.
